// File: rtl/line_feeder.sv
// rtl/line_feeder.sv - raster-to-column reorder stage emitting top/mid/bot beats per pixel; top-edge replication under LINE_FEEDER_BORDER_EN
module line_feeder #(
    parameter int DataBitWidth = 4,
    parameter int Channels     = 3,
    parameter int ImgWidth     = 8,
    parameter int ImgHeight    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             px_valid,
    input  logic                             px_sof,
    input  logic [DataBitWidth*Channels-1:0] px_in,
    output logic                             px_ready,
    output logic                             en,
    output logic [DataBitWidth*Channels-1:0] d_out,
    output logic                             eof_out
);
    localparam int PW = DataBitWidth * Channels;
    localparam int CW = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
    localparam int RW = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(ImgWidth - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ImgHeight - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT_TOP = 2'd1,
        EMIT_MID = 2'd2,
        EMIT_BOT = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic [PW-1:0] line0 [ImgWidth];
    logic [PW-1:0] line1 [ImgWidth];
    logic [PW-1:0] top;
    logic [PW-1:0] mid;
    logic [PW-1:0] bot;
    logic          last_px;
    logic          accept;
    logic          produce;

    // Start of frame overrides whatever position the counters hold.
    always_comb begin
        pos_col = px_sof ? '0 : col;
        pos_row = px_sof ? '0 : row;
    end

    assign accept = px_valid && px_ready;

`ifdef LINE_FEEDER_BORDER_EN
    assign produce = 1'b1;
`else
    assign produce = (pos_row >= RW'(2));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ImgWidth; i++) begin
                line0[i] <= '0;
                line1[i] <= '0;
            end
            top     <= '0;
            mid     <= '0;
            bot     <= '0;
            last_px <= 1'b0;
        end else if (accept) begin
            line1[pos_col] <= line0[pos_col];
            line0[pos_col] <= px_in;
            bot            <= px_in;
            last_px        <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
`ifdef LINE_FEEDER_BORDER_EN
            // Top edge: rows above the image replicate the first line.
            if (pos_row == '0) begin
                top <= px_in;
                mid <= px_in;
            end else if (pos_row == RW'(1)) begin
                top <= line0[pos_col];
                mid <= line0[pos_col];
            end else begin
                top <= line1[pos_col];
                mid <= line0[pos_col];
            end
`else
            top <= line1[pos_col];
            mid <= line0[pos_col];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = (accept && produce) ? EMIT_TOP : IDLE;
            EMIT_TOP: state_next = EMIT_MID;
            EMIT_MID: state_next = EMIT_BOT;
            EMIT_BOT: state_next = (accept && produce) ? EMIT_TOP : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        px_ready = 1'b0;
        en       = 1'b0;
        d_out    = '0;
        eof_out  = 1'b0;
        case (state)
            IDLE: begin
                px_ready = !rst;
            end
            EMIT_TOP: begin
                en    = 1'b1;
                d_out = top;
            end
            EMIT_MID: begin
                en    = 1'b1;
                d_out = mid;
            end
            EMIT_BOT: begin
                en       = 1'b1;
                d_out    = bot;
                eof_out  = last_px;
                px_ready = !rst;
            end
            default: begin
                px_ready = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_line_feeder.sv
// tb/tb_line_feeder.sv - self-checking bench for line_feeder against a frame-image reference model
module tb_line_feeder;
    localparam int DW = 4;
    localparam int CH = 3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = DW * CH;
`ifdef LINE_FEEDER_BORDER_EN
    localparam int FRAME_BEATS = 3 * W * H;
`else
    localparam int FRAME_BEATS = 3 * W * (H - 2);
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          px_valid;
    logic          px_sof;
    logic [PW-1:0] px_in;
    logic          px_ready;
    logic          en;
    logic [PW-1:0] d_out;
    logic          eof_out;

    always #5 clk = ~clk;

    line_feeder #(
        .DataBitWidth(DW),
        .Channels(CH),
        .ImgWidth(W),
        .ImgHeight(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .px_valid(px_valid),
        .px_sof(px_sof),
        .px_in(px_in),
        .px_ready(px_ready),
        .en(en),
        .d_out(d_out),
        .eof_out(eof_out)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            en_count = 0;
    int            m_row    = 0;
    int            m_col    = 0;
    logic [PW-1:0] img [H][W];
    logic [PW:0]   beats [$];

    task automatic check(input string tag, input logic [PW:0] obs, input logic [PW:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pat(input int r, input int c);
        logic [DW-1:0] s;
        s = DW'(r * W + c);
        return {CH{s}};
    endfunction

    // Model: the column at (r,c) is rows r-2, r-1, r of the frame image.
    task automatic model_accept(input logic sof, input logic [PW-1:0] px);
        logic lst;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = px;
        lst = (m_row == H - 1) && (m_col == W - 1);
        if (m_row >= 2) begin
            beats.push_back({1'b0, img[m_row-2][m_col]});
            beats.push_back({1'b0, img[m_row-1][m_col]});
            beats.push_back({lst, px});
        end
`ifdef LINE_FEEDER_BORDER_EN
        else if (m_row == 1) begin
            beats.push_back({1'b0, img[0][m_col]});
            beats.push_back({1'b0, img[0][m_col]});
            beats.push_back({lst, px});
        end else begin
            beats.push_back({1'b0, px});
            beats.push_back({1'b0, px});
            beats.push_back({lst, px});
        end
`endif
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic cycle(input logic v, input logic sof, input logic [PW-1:0] px,
                         input logic r, output logic acc);
        logic        exp_rdy;
        logic [PW:0] f;
        rst      = r;
        px_valid = v;
        px_sof   = sof;
        px_in    = px;
        #1;
        exp_rdy = !r && (beats.size() <= 1);
        check("px_ready", {{PW{1'b0}}, px_ready}, {{PW{1'b0}}, exp_rdy});
        if (!r) begin
            f = (beats.size() != 0) ? beats[0] : '0;
            check("en", {{PW{1'b0}}, en}, {{PW{1'b0}}, beats.size() != 0});
            check("d_out", {1'b0, d_out}, {1'b0, f[PW-1:0]});
            check("eof_out", {{PW{1'b0}}, eof_out}, {{PW{1'b0}}, f[PW]});
            if (en === 1'b1) en_count++;
        end
        acc = v && exp_rdy;
        if (r) begin
            beats.delete();
            m_row = 0;
            m_col = 0;
        end else begin
            if (beats.size() != 0) void'(beats.pop_front());
            if (acc) model_accept(sof, px);
        end
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic sof, input logic [PW-1:0] px);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) cycle(1'b1, sof, px, 1'b0, acc);
        if (!acc) check_count("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic send_frame(input int pause_after);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel(r == 0 && c == 0, pat(r, c));
                if (r * W + c == pause_after) idle(5);
            end
        end
    endtask

    initial begin
        logic acc;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = '0;
        rst = 1'b1;
        px_valid = 1'b0;
        px_sof = 1'b0;
        px_in = '0;
        @(negedge clk);
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        idle(2);

        en_count = 0;
        send_frame(-1);
        idle(4);
        check_count("frame1_en_beats", en_count, FRAME_BEATS);

        en_count = 0;
        send_frame(2 * W + 1);
        idle(4);
        check_count("frame2_en_beats", en_count, FRAME_BEATS);

        // Reset lands while the row 3 col 1 triple is in EMIT_MID.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r * W + c <= 3 * W + 1) send_pixel(r == 0 && c == 0, pat(r, c));
        cycle(1'b0, 1'b0, '0, 1'b0, acc);
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        idle(1);

        en_count = 0;
        send_frame(-1);
        idle(4);
        check_count("frame4_en_beats", en_count, FRAME_BEATS);

        for (int k = 0; k < 300; k++) begin
            cycle(($urandom % 4) != 0, ($urandom % 24) == 0, PW'($urandom), 1'b0, acc);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
